uart_byte_rx: RTL and testbench
===============================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clk frequency in Hz.
REQ-002 Parameter BAUD, default 1000000, serial bit rate in bit/s.
REQ-003 One clock; reset is asynchronous and active-high (ports clk and rst).
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 rx  input  1  raw serial line from usb_rx pad, asynchronous to clk, idle high, 8N1, LSB first.
REQ-007 data  output  8  last correctly framed byte.
REQ-008 new_data  output  1  one-cycle strobe: data just updated.
REQ-009 frame_err  output  1  one-cycle strobe: stop bit sampled low.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 CPB = CLK_FREQ/BAUD (integer division); elaboration SHALL fail if CPB < 8. The bit counter width is clog2(CPB).
REQ-012 rx passes through a 2-flop synchronizer (reset value 1) before any use; all statements below refer to the synchronized value rxs.
REQ-013 States: IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: rxs=0 -> START, counter cleared. Otherwise stay.
REQ-015 START: the start-bit sample is taken CPB/2 cycles after entry. rxs=0 -> DATA (bit index 0). rxs=1 -> IDLE as a glitch, with no strobe.
REQ-016 DATA: bit n is sampled exactly CPB cycles after the previous sample and stored at data-shift position n (LSB first). After bit 7 -> STOP.
REQ-017 STOP: the stop bit is sampled CPB cycles after bit 7.
  - rxs=1: load data from the shift register, pulse new_data for one cycle, -> IDLE.
  - rxs=0: pulse frame_err for one cycle, leave data unchanged, -> BREAK.
REQ-018 BREAK: stay until rxs=1, then -> IDLE. No new start is accepted while in BREAK.
REQ-019 Timing: let t0 be the first clk edge that samples pin rx low from idle.
  - Start sample at t0+2+CPB/2.
  - Bit n sample at t0+2+CPB/2+(n+1)*CPB.
  - Stop sample at t0+2+CPB/2+9*CPB.
  - new_data or frame_err is high during the cycle after the stop sample.
REQ-020 A falling edge arriving in the cycle right after the stop sample is accepted as the next start bit. Back-to-back frames lose no byte.
REQ-021 new_data and frame_err are never high in the same cycle. Neither is ever high for more than one cycle.
REQ-022 data holds its value between strobes. There is no downstream handshake: a consumer that misses a strobe loses that byte.

Reset
REQ-023 While rst=1, the following hold regardless of rx:
  - state=IDLE, counters=0, synchronizer=1.
  - data=8'h00, new_data=0, frame_err=0, busy=0.
REQ-024 Reset asserted mid-frame abandons the frame with no strobe. After release, the block waits for a fresh falling edge.

Structure
REQ-025 A shared package uart_pkg holds:
  - the state enum uart_rx_state_t (IDLE, START, DATA, STOP, BREAK);
  - the constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1.
REQ-026 The synchronizer is the single sub-module sync_2ff (1-bit, reset value parameterized), reusable for other pad inputs.

Verification (CLK_FREQ=100000000, BAUD=1000000, CPB=100, t0=0)
REQ-027 Frame 0x55, valid stop -> new_data high only in cycle 953, data=8'h55, frame_err stays 0, busy falls at 953.
REQ-028 Frames 0x00 then 0xFF, zero idle gap -> two new_data strobes exactly 1000 cycles apart, data=8'h00 then 8'hFF.
REQ-029 rx low pulse of 20 cycles then high -> no strobe, busy returns to 0 by cycle 53, data unchanged.
REQ-030 Frame 0xA5 with stop bit low, rx held low 300 further cycles, then frame 0x3C -> frame_err high in cycle 953. data keeps its prior value. No start is accepted while low. 0x3C is then received normally.
REQ-031 rst pulsed during bit 4 of frame 0x81 -> all outputs 0 during reset, no strobe for the aborted frame, next full frame 0x81 yields data=8'h81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_t;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pad input.
// The reset value is a parameter so the idle level of the pad can be matched.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Capture the pad, then re-register to let metastability settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver, LSB first, one sample per bit at mid-bit.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | line high, waiting for a falling edge
//   START | half-bit wait, then confirm the start bit is still low
//   DATA  | sampling eight data bits, one bit period apart
//   STOP  | sampling the stop bit; high -> byte out, low -> frame error
//   BREAK | line held low after a bad stop bit; wait for it to go high
//
// The bit timer is a down-counter loaded with (period - 1) and sampled at
// terminal count zero.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 1000000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx,
   output logic [UART_DATA_BITS-1:0] data,
   output logic                      new_data,
   output logic                      frame_err,
   output logic                      busy
);

   localparam int CPB   = CLK_FREQ / BAUD;
   localparam int CNT_W = $clog2(CPB);
   localparam int BIT_W = $clog2(UART_DATA_BITS);

   localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CPB / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CPB - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

   // Below 8 clocks per bit the mid-bit sample point is too coarse to trust.
   if (CPB < 8) begin : g_bad_cpb
      $error("uart_byte_rx: CLK_FREQ/BAUD must be at least 8");
   end

   logic rxs;

   sync_2ff #(
      .RST_VAL (UART_IDLE_LEVEL)
   ) u_sync_rx (
      .clk (clk),
      .rst (rst),
      .d_i (rx),
      .q_o (rxs)
   );

   uart_rx_state_t            state_q,     state_d;
   logic [CNT_W-1:0]          cnt_q,       cnt_d;
   logic [BIT_W-1:0]          bit_idx_q,   bit_idx_d;
   logic [UART_DATA_BITS-1:0] shift_q,     shift_d;
   logic [UART_DATA_BITS-1:0] data_q,      data_d;
   logic                      new_data_q,  new_data_d;
   logic                      frame_err_q, frame_err_d;

   // State, timer, shift register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         new_data_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         new_data_q  <= new_data_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state and sampling decisions; strobes default low so they last one cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      new_data_d  = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rxs) begin
               state_d = START;
               cnt_d   = HALF_TC;
            end
         end

         START: begin
            if (cnt_q == '0) begin
               if (!rxs) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
                  cnt_d     = FULL_TC;
               end else begin
                  // Low pulse shorter than half a bit: treat as noise.
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         DATA: begin
            if (cnt_q == '0) begin
               shift_d[bit_idx_q] = rxs;
               cnt_d              = FULL_TC;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         STOP: begin
            if (cnt_q == '0) begin
               if (rxs == UART_IDLE_LEVEL) begin
                  data_d     = shift_q;
                  new_data_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         BREAK: begin
            if (rxs == UART_IDLE_LEVEL) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign data      = data_q;
   assign new_data  = new_data_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed scenarios followed by
// random frames, checked against an event-level model of the receiver.
module tb_uart_byte_rx;

   localparam int CLK_FREQ   = 100000000;
   localparam int BAUD       = 1000000;
   localparam int CPB        = CLK_FREQ / BAUD;
   localparam int STROBE_OFF = 2 + CPB / 2 + 9 * CPB;
   localparam int GLITCH_OFF = 2 + CPB / 2;

   typedef struct {
      int         cyc;
      bit         is_err;
      logic [7:0] dat;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       new_data;
   logic       frame_err;
   logic       busy;

   int         cyc = 0;
   logic       busy_prev = 1'b0;
   ev_t        mon_ev;
   ev_t        obs_q[$];
   ev_t        exp_q[$];
   int         bf_q[$];
   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] model_data;

   uart_byte_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (data),
      .new_data  (new_data),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Edge index: after the k-th rising edge, cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   // Record every strobe cycle and every busy falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (new_data) begin
            mon_ev.cyc = cyc; mon_ev.is_err = 1'b0; mon_ev.dat = data;
            obs_q.push_back(mon_ev);
         end
         if (frame_err) begin
            mon_ev.cyc = cyc; mon_ev.is_err = 1'b1; mon_ev.dat = data;
            obs_q.push_back(mon_ev);
         end
         if (busy_prev && !busy) bf_q.push_back(cyc);
      end
      busy_prev = busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      wait_cycles(CPB);
   endtask

   // Model: a frame whose first low sample is edge t0 produces its strobe
   // in the cycle following edge t0 + 2 + CPB/2 + 9*CPB.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
      t0 = cyc + 1;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_bit);
   endtask

   task automatic add_exp(input int c, input bit is_err, input logic [7:0] d);
      ev_t e;
      e.cyc = c; e.is_err = is_err; e.dat = d;
      exp_q.push_back(e);
   endtask

   task automatic check_events(input string tag);
      chk({tag, " strobe count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         chk($sformatf("%s ev%0d cycle", tag, i), obs_q[i].cyc, exp_q[i].cyc);
         chk($sformatf("%s ev%0d kind", tag, i), 32'(obs_q[i].is_err), 32'(exp_q[i].is_err));
         chk($sformatf("%s ev%0d data", tag, i), 32'(obs_q[i].dat), 32'(exp_q[i].dat));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      chk({tag, " data"}, 32'(data), 32'h0);
      chk({tag, " new_data"}, 32'(new_data), 32'h0);
      chk({tag, " frame_err"}, 32'(frame_err), 32'h0);
      chk({tag, " busy"}, 32'(busy), 32'h0);
   endtask

   initial begin
      int         t0;
      int         t1;
      int         gap;
      logic [7:0] b;
      bit         ok;
      logic [7:0] pat;

      // Reset with a noisy line.
      rst = 1'b1;
      rx  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         rx = 1'($urandom);
      end
      check_reset_outputs("por");
      @(posedge clk); #1;
      rx  = 1'b1;
      rst = 1'b0;
      model_data = 8'h00;
      wait_cycles(5);
      obs_q.delete();
      bf_q.delete();

      // Single valid frame 0x55.
      send_frame(8'h55, 1'b1, t0);
      add_exp(t0 + STROBE_OFF, 1'b0, 8'h55);
      model_data = 8'h55;
      wait_cycles(5);
      check_events("f55");
      chk("f55 busy falls", bf_q.size(), 1);
      if (bf_q.size() > 0) chk("f55 busy fall cycle", bf_q[0], t0 + STROBE_OFF);
      chk("f55 data held", 32'(data), 32'h55);

      // Back-to-back 0x00 then 0xFF, no idle gap.
      send_frame(8'h00, 1'b1, t0);
      send_frame(8'hFF, 1'b1, t1);
      add_exp(t0 + STROBE_OFF, 1'b0, 8'h00);
      add_exp(t1 + STROBE_OFF, 1'b0, 8'hFF);
      model_data = 8'hFF;
      wait_cycles(5);
      check_events("b2b");

      // 20-cycle low glitch.
      bf_q.delete();
      t0 = cyc + 1;
      rx = 1'b0;
      wait_cycles(20);
      rx = 1'b1;
      wait_cycles(150);
      check_events("glitch");
      chk("glitch busy falls", bf_q.size(), 1);
      if (bf_q.size() > 0) chk("glitch busy fall cycle", bf_q[0], t0 + GLITCH_OFF);
      chk("glitch data held", 32'(data), 32'(model_data));

      // Bad stop bit, long break, then a normal frame.
      send_frame(8'hA5, 1'b0, t0);
      add_exp(t0 + STROBE_OFF, 1'b1, model_data);
      wait_cycles(300);
      rx = 1'b1;
      wait_cycles(5);
      send_frame(8'h3C, 1'b1, t1);
      add_exp(t1 + STROBE_OFF, 1'b0, 8'h3C);
      model_data = 8'h3C;
      wait_cycles(5);
      check_events("brk");

      // Reset in the middle of bit 4 of 0x81.
      pat = 8'h81;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(pat[i]);
      rx = pat[4];
      wait_cycles(CPB / 2);
      rst = 1'b1;
      wait_cycles(2);
      rx = 1'b1;
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      model_data = 8'h00;
      wait_cycles(1200);
      check_events("midrst abort");
      chk("midrst data", 32'(data), 32'h0);
      send_frame(8'h81, 1'b1, t0);
      add_exp(t0 + STROBE_OFF, 1'b0, 8'h81);
      model_data = 8'h81;
      wait_cycles(5);
      check_events("f81");
      chk("f81 data", 32'(data), 32'h81);

      // Random frames with random gaps and occasional bad stop bits.
      for (int i = 0; i < 8; i++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(0, 3) != 0);
         send_frame(b, ok, t0);
         if (ok) begin
            add_exp(t0 + STROBE_OFF, 1'b0, b);
            model_data = b;
         end else begin
            add_exp(t0 + STROBE_OFF, 1'b1, model_data);
            wait_cycles(int'($urandom_range(1, 200)));
            rx = 1'b1;
            wait_cycles(3);
         end
         gap = int'($urandom_range(0, 40));
         if (gap > 0) begin
            rx = 1'b1;
            wait_cycles(gap);
         end
      end
      rx = 1'b1;
      wait_cycles(20);
      check_events("rnd");
      chk("rnd final data", 32'(data), 32'(model_data));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
